pipe_hazard_unit: RTL and testbench

- Parametrised scoreboard for the pipelined RISC-V core. It tracks destination and control metadata for every in-flight instruction past ID.
- From that metadata it produces load-use stall, bubble insertion, EX-stage forwarding selects and ID-stage writeback bypass flags.
- It sits beside the ID/EX/MEM/WB pipeline registers and replaces the always-load pipeline advance. It generalises the number of tracked stages and the load-data latency.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/hz_stage_reg.sv | 21 ++
 rtl/pipe_hazard_unit.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard.
// Register addresses are stored zero-extended to HZ_RD_W so one entry type serves any AW up to 8.
package pipe_pkg;

  localparam int HZ_RD_W = 8;
  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;

  typedef struct packed {
    logic               valid;
    logic [HZ_RD_W-1:0] rd;
    logic               regwrite;
    logic               memread;
  } hz_entry_t;

  // A producer only counts when it really writes a non-x0 register the consumer reads.
  function automatic logic fw_match(input hz_entry_t entry,
                                    input logic [HZ_RD_W-1:0] src,
                                    input logic use_src);
    return entry.valid && entry.regwrite && (entry.rd != '0) && (entry.rd == src) && use_src;
  endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One scoreboard entry: destination/control metadata of the instruction in a single stage.
// Cleared by the synchronous active-low reset and frozen while hold is high.
module hz_stage_reg
  import pipe_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      hold,
  input  hz_entry_t d,
  output hz_entry_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard scoreboard beside the ID/EX/MEM/WB registers: load-use stall, bubble insertion,
// EX forwarding selects and ID write-back bypass, all derived from per-stage metadata.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 3,
  parameter int FW         = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          iHold,
  input  logic          iID_Valid,
  input  logic [AW-1:0] iID_Rs1,
  input  logic [AW-1:0] iID_Rs2,
  input  logic          iID_Use1,
  input  logic          iID_Use2,
  input  logic [AW-1:0] iID_Rd,
  input  logic          iID_RegWrite,
  input  logic          iID_MemRead,
  input  logic          iFlush,
  output logic          oStall,
  output logic          oBubble,
  output logic [FW-1:0] oFwdSel1,
  output logic [FW-1:0] oFwdSel2,
  output logic          oWbBypass1,
  output logic          oWbBypass2
);

  hz_entry_t stage_d [1:DEPTH];
  hz_entry_t stage_q [1:DEPTH];
  hz_entry_t id_entry;

  logic [HZ_RD_W-1:0] id_rs1;
  logic [HZ_RD_W-1:0] id_rs2;
  logic [HZ_RD_W-1:0] ex_rs1;
  logic [HZ_RD_W-1:0] ex_rs2;
  logic               ex_use1;
  logic               ex_use2;
  logic               load_hit;

  assign id_rs1 = HZ_RD_W'(iID_Rs1);
  assign id_rs2 = HZ_RD_W'(iID_Rs2);

  // A load at stage j has its data on a result bus only from LOAD_READY on; if the ID
  // consumer would reach EX before then, it has to wait.
  always_comb begin
    load_hit = 1'b0;
    for (int j = STG_EX; j <= LOAD_READY - 2; j++) begin
      if (stage_q[j].memread &&
          (fw_match(stage_q[j], id_rs1, iID_Use1) || fw_match(stage_q[j], id_rs2, iID_Use2))) begin
        load_hit = 1'b1;
      end
    end
  end

  assign oStall  = iID_Valid && !iFlush && load_hit;
  assign oBubble = oStall || iFlush;

  always_comb begin
    id_entry = '0;
    if (iID_Valid && !oBubble) begin
      id_entry.valid    = 1'b1;
      id_entry.rd       = HZ_RD_W'(iID_Rd);
      id_entry.regwrite = iID_RegWrite;
      id_entry.memread  = iID_MemRead;
    end
  end

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    if (k == STG_EX) begin : g_head
      assign stage_d[k] = id_entry;
    end else begin : g_chain
      assign stage_d[k] = stage_q[k-1];
    end

    hz_stage_reg u_reg (
      .clk  (Clk),
      .rst_n(Reset),
      .hold (iHold),
      .d    (stage_d[k]),
      .q    (stage_q[k])
    );
  end

  // The EX entry also remembers its own sources so forwarding can be resolved in EX.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ex_rs1  <= '0;
      ex_rs2  <= '0;
      ex_use1 <= 1'b0;
      ex_use2 <= 1'b0;
    end else if (!iHold) begin
      ex_rs1  <= id_rs1;
      ex_rs2  <= id_rs2;
      ex_use1 <= iID_Use1 && !oBubble;
      ex_use2 <= iID_Use2 && !oBubble;
    end
  end

  // Scanning oldest to youngest lets the youngest eligible producer overwrite the select.
  always_comb begin
    oFwdSel1 = '0;
    oFwdSel2 = '0;
    if (stage_q[STG_EX].valid) begin
      for (int k = DEPTH; k >= STG_MEM; k--) begin
        if (!(stage_q[k].memread && (k < LOAD_READY))) begin
          if (fw_match(stage_q[k], ex_rs1, ex_use1)) begin
            oFwdSel1 = FW'(k);
          end
          if (fw_match(stage_q[k], ex_rs2, ex_use2)) begin
            oFwdSel2 = FW'(k);
          end
        end
      end
    end
  end

  assign oWbBypass1 = iID_Valid && fw_match(stage_q[DEPTH], id_rs1, iID_Use1);
  assign oWbBypass2 = iID_Valid && fw_match(stage_q[DEPTH], id_rs2, iID_Use2);

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: a default instance (DEPTH=3, LOAD_READY=3) and a deep one
// (DEPTH=4, LOAD_READY=4), each shadowed by an instruction-level pipeline model.
module tb_pipe_hazard_unit;

  localparam int D0  = 3;
  localparam int LR0 = 3;
  localparam int D1  = 4;
  localparam int LR1 = 4;

  typedef struct {
    bit hold, valid, flush;
    int rs1, rs2, rd;
    bit u1, u2, rw, mr;
  } in_t;

  typedef struct {
    int stall, bubble, f1, f2, b1, b2;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t exp;
  } vec_t;

  typedef struct {
    bit valid, rw, mr, u1, u2;
    int rd, rs1, rs2;
  } slot_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       hold_v  [2];
  logic       valid_v [2];
  logic       use1_v  [2];
  logic       use2_v  [2];
  logic       rw_v    [2];
  logic       mr_v    [2];
  logic       flush_v [2];
  logic [4:0] rs1_v   [2];
  logic [4:0] rs2_v   [2];
  logic [4:0] rd_v    [2];
  logic       stall_v [2];
  logic       bubble_v[2];
  logic       b1_v    [2];
  logic       b2_v    [2];
  logic [1:0] f1_0, f2_0;
  logic [2:0] f1_1, f2_1;

  pipe_hazard_unit #(.AW(5), .DEPTH(D0), .LOAD_READY(LR0)) dut0 (
    .Clk(clk), .Reset(reset_n), .iHold(hold_v[0]), .iID_Valid(valid_v[0]),
    .iID_Rs1(rs1_v[0]), .iID_Rs2(rs2_v[0]), .iID_Use1(use1_v[0]), .iID_Use2(use2_v[0]),
    .iID_Rd(rd_v[0]), .iID_RegWrite(rw_v[0]), .iID_MemRead(mr_v[0]), .iFlush(flush_v[0]),
    .oStall(stall_v[0]), .oBubble(bubble_v[0]), .oFwdSel1(f1_0), .oFwdSel2(f2_0),
    .oWbBypass1(b1_v[0]), .oWbBypass2(b2_v[0])
  );

  pipe_hazard_unit #(.AW(5), .DEPTH(D1), .LOAD_READY(LR1)) dut1 (
    .Clk(clk), .Reset(reset_n), .iHold(hold_v[1]), .iID_Valid(valid_v[1]),
    .iID_Rs1(rs1_v[1]), .iID_Rs2(rs2_v[1]), .iID_Use1(use1_v[1]), .iID_Use2(use2_v[1]),
    .iID_Rd(rd_v[1]), .iID_RegWrite(rw_v[1]), .iID_MemRead(mr_v[1]), .iFlush(flush_v[1]),
    .oStall(stall_v[1]), .oBubble(bubble_v[1]), .oFwdSel1(f1_1), .oFwdSel2(f2_1),
    .oWbBypass1(b1_v[1]), .oWbBypass2(b2_v[1])
  );

  int    n_vec = 0;
  int    n_bad = 0;
  in_t   cur [2];
  slot_t pipe [2][1:8];
  int    depth_of [2] = '{D0, D1};
  int    ready_of [2] = '{LR0, LR1};

  function automatic in_t mk(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit rw, bit mr);
    in_t x;
    x.hold = 0; x.flush = 0; x.valid = v;
    x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
    x.rd = rd; x.rw = rw; x.mr = mr;
    return x;
  endfunction

  function automatic out_t ex(int s, int b, int f1, int f2, int b1, int b2);
    out_t o;
    o.stall = s; o.bubble = b; o.f1 = f1; o.f2 = f2; o.b1 = b1; o.b2 = b2;
    return o;
  endfunction

  function automatic bit writes(slot_t s, int r, bit u);
    return s.valid && s.rw && (s.rd != 0) && (s.rd == r) && u;
  endfunction

  // Expected outputs for instance d from the in-flight instructions and its current ID inputs.
  function automatic out_t model_out(int d);
    out_t  o   = ex(0, 0, 0, 0, 0, 0);
    in_t   x   = cur[d];
    int    dep = depth_of[d];
    int    rdy = ready_of[d];
    slot_t e1  = pipe[d][1];
    // A load j stages past ID still needs (rdy - j) cycles; the consumer would need it in one.
    for (int j = 1; j <= dep; j++) begin
      if (pipe[d][j].mr && (rdy - j) > 1 &&
          (writes(pipe[d][j], x.rs1, x.u1) || writes(pipe[d][j], x.rs2, x.u2)))
        o.stall = 1;
    end
    if (!x.valid || x.flush) o.stall = 0;
    o.bubble = (o.stall != 0 || x.flush) ? 1 : 0;
    if (e1.valid) begin
      for (int k = 2; k <= dep; k++) begin
        if (writes(pipe[d][k], e1.rs1, e1.u1) && (k >= rdy || !pipe[d][k].mr)) begin
          o.f1 = k;
          break;
        end
      end
      for (int k = 2; k <= dep; k++) begin
        if (writes(pipe[d][k], e1.rs2, e1.u2) && (k >= rdy || !pipe[d][k].mr)) begin
          o.f2 = k;
          break;
        end
      end
    end
    o.b1 = (x.valid && writes(pipe[d][dep], x.rs1, x.u1)) ? 1 : 0;
    o.b2 = (x.valid && writes(pipe[d][dep], x.rs2, x.u2)) ? 1 : 0;
    return o;
  endfunction

  task automatic model_step(int d, bit rst_low);
    out_t o   = model_out(d);
    int   dep = depth_of[d];
    in_t  x   = cur[d];
    if (rst_low) begin
      for (int k = 1; k <= 8; k++) pipe[d][k].valid = 0;
    end else if (!x.hold) begin
      for (int k = dep; k >= 2; k--) pipe[d][k] = pipe[d][k-1];
      pipe[d][1].valid = x.valid && (o.bubble == 0);
      pipe[d][1].rd = x.rd; pipe[d][1].rw = x.rw; pipe[d][1].mr = x.mr;
      pipe[d][1].rs1 = x.rs1; pipe[d][1].rs2 = x.rs2;
      pipe[d][1].u1 = x.u1; pipe[d][1].u2 = x.u2;
    end
  endtask

  function automatic out_t read_out(int d);
    out_t o;
    o.stall  = int'(stall_v[d]);
    o.bubble = int'(bubble_v[d]);
    o.f1     = (d == 0) ? int'(f1_0) : int'(f1_1);
    o.f2     = (d == 0) ? int'(f2_0) : int'(f2_1);
    o.b1     = int'(b1_v[d]);
    o.b2     = int'(b2_v[d]);
    return o;
  endfunction

  task automatic drive(input int d, input in_t x);
    cur[d]      = x;
    hold_v[d]   = x.hold;
    valid_v[d]  = x.valid;
    flush_v[d]  = x.flush;
    rs1_v[d]    = 5'(x.rs1);
    rs2_v[d]    = 5'(x.rs2);
    rd_v[d]     = 5'(x.rd);
    use1_v[d]   = x.u1;
    use2_v[d]   = x.u2;
    rw_v[d]     = x.rw;
    mr_v[d]     = x.mr;
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input out_t act, input out_t exp);
    check_output({tag, ".stall"},  act.stall,  exp.stall);
    check_output({tag, ".bubble"}, act.bubble, exp.bubble);
    check_output({tag, ".fwd1"},   act.f1,     exp.f1);
    check_output({tag, ".fwd2"},   act.f2,     exp.f2);
    check_output({tag, ".wb1"},    act.b1,     exp.b1);
    check_output({tag, ".wb2"},    act.b2,     exp.b2);
  endtask

  // Called with inputs already driven after a falling edge: check both instances, advance, wait a cycle.
  task automatic tick();
    #1;
    for (int d = 0; d < 2; d++) check_all($sformatf("model%0d", d), read_out(d), model_out(d));
    for (int d = 0; d < 2; d++) model_step(d, !reset_n);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic in_t rand_in();
    in_t x;
    x.hold  = ($urandom_range(0, 9) == 0);
    x.flush = ($urandom_range(0, 7) == 0);
    x.valid = ($urandom_range(0, 3) != 0);
    x.rs1   = int'($urandom_range(0, 3));
    x.rs2   = int'($urandom_range(0, 3));
    x.rd    = int'($urandom_range(0, 3));
    x.u1    = 1'($urandom_range(0, 1));
    x.u2    = 1'($urandom_range(0, 1));
    x.rw    = ($urandom_range(0, 4) != 0);
    x.mr    = ($urandom_range(0, 2) == 0);
    return x;
  endfunction

  initial begin
    vec_t tbl [18];
    in_t  idle, lw7, add8, x;
    int   stalls;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    lw7  = mk(1, 1, 1, 0, 0, 7, 1, 0);
    lw7.mr = 1;
    add8 = mk(1, 7, 1, 2, 1, 8, 1, 0);

    tbl[0]  = '{mk(1, 0, 1, 0, 0, 5, 1, 0),  ex(0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{mk(1, 5, 1, 5, 1, 6, 1, 0),  ex(0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{idle,                        ex(0, 0, 2, 2, 0, 0)};
    tbl[3]  = '{idle,                        ex(0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{lw7,                         ex(0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{add8,                        ex(1, 1, 0, 0, 0, 0)};
    tbl[6]  = '{add8,                        ex(0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{idle,                        ex(0, 0, 3, 0, 0, 0)};
    tbl[8]  = '{idle,                        ex(0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{idle,                        ex(0, 0, 0, 0, 0, 0)};
    tbl[10] = '{mk(1, 0, 1, 0, 0, 9, 1, 0),  ex(0, 0, 0, 0, 0, 0)};
    tbl[11] = '{mk(1, 0, 1, 0, 0, 9, 1, 0),  ex(0, 0, 0, 0, 0, 0)};
    tbl[12] = '{mk(1, 9, 1, 0, 1, 10, 1, 0), ex(0, 0, 0, 0, 0, 0)};
    tbl[13] = '{mk(1, 9, 1, 9, 1, 11, 1, 0), ex(0, 0, 2, 0, 1, 1)};
    tbl[14] = '{idle,                        ex(0, 0, 3, 3, 0, 0)};
    tbl[15] = '{mk(1, 1, 1, 0, 0, 0, 1, 1),  ex(0, 0, 0, 0, 0, 0)};
    tbl[16] = '{mk(1, 0, 1, 0, 1, 12, 1, 0), ex(0, 0, 0, 0, 0, 0)};
    tbl[17] = '{idle,                        ex(0, 0, 0, 0, 0, 0)};

    // Reset held for two cycles while ID presents a valid load of x5.
    reset_n = 1'b0;
    x = lw7;
    x.rd = 5;
    drive(0, x);
    drive(1, x);
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      #1;
      check_output("rst.stall", int'(stall_v[0]), 0);
      check_output("rst.fwd1", int'(f1_0), 0);
      check_output("rst.fwd2", int'(f2_0), 0);
      tick();
    end
    reset_n = 1'b1;
    drive(0, mk(1, 5, 1, 5, 1, 6, 1, 0));
    drive(1, mk(1, 5, 1, 5, 1, 6, 1, 0));
    #1;
    check_output("rst.release_stall0", int'(stall_v[0]), 0);
    check_output("rst.release_stall1", int'(stall_v[1]), 0);
    tick();
    drive(0, idle);
    drive(1, idle);
    for (int c = 0; c < 3; c++) tick();

    for (int i = 0; i < 18; i++) begin
      drive(0, tbl[i].stim);
      #1;
      check_all($sformatf("vec%0d", i), read_out(0), tbl[i].exp);
      tick();
    end

    // Deep pipeline: a load needs two stall cycles before its consumer may enter EX.
    drive(0, idle);
    drive(1, lw7);
    tick();
    drive(1, add8);
    stalls = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (stall_v[1] !== 1'b1) break;
      stalls++;
      tick();
    end
    check_output("d4.stall_cycles", stalls, 2);
    tick();
    drive(1, idle);
    #1;
    check_output("d4.fwd1", int'(f1_1), 4);
    tick();

    // Flush on the cycle a load-use stall would fire: only ID dies, the load keeps moving.
    drive(0, lw7);
    tick();
    x = add8;
    x.flush = 1;
    drive(0, x);
    #1;
    check_output("flush.stall", int'(stall_v[0]), 0);
    check_output("flush.bubble", int'(bubble_v[0]), 1);
    tick();
    drive(0, idle);
    tick();
    drive(0, mk(1, 7, 1, 0, 0, 9, 1, 0));
    #1;
    check_output("flush.load_reaches_wb", int'(b1_v[0]), 1);
    tick();

    // Three held cycles with a forwarding pair in EX/MEM.
    drive(0, idle);
    for (int c = 0; c < 3; c++) tick();
    drive(0, mk(1, 0, 1, 0, 0, 5, 1, 0));
    tick();
    drive(0, mk(1, 5, 1, 5, 1, 6, 1, 0));
    tick();
    x = idle;
    x.hold = 1;
    drive(0, x);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_output($sformatf("hold%0d.fwd1", c), int'(f1_0), 2);
      check_output($sformatf("hold%0d.fwd2", c), int'(f2_0), 2);
      tick();
    end
    drive(0, idle);
    #1;
    check_output("hold.release_fwd1", int'(f1_0), 2);
    tick();
    #1;
    check_output("hold.advanced_fwd1", int'(f1_0), 0);

    // Reset arriving during a stall clears it on the next cycle.
    for (int c = 0; c < 3; c++) tick();
    drive(0, lw7);
    tick();
    drive(0, add8);
    #1;
    check_output("rststall.before", int'(stall_v[0]), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check_output("rststall.after", int'(stall_v[0]), 0);
    tick();

    for (int c = 0; c < 600; c++) begin
      drive(0, rand_in());
      drive(1, rand_in());
      reset_n = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
